if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the pipelined CPU. It owns the PC and drives the instruction-memory address. It captures fetched instructions into the IF/ID register consumed by the ID-stage decoder and control unit. It applies the `pcsource` redirect coming back from ID and detects load-use hazards, stalling IF/ID and requesting a bubble into ID/EX.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, 16, width of the stall performance counter.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `pcsource`  in  2  next-PC select from control unit: 00 pc+4, 01 branch target, 10 jump target, 11 illegal opcode (treated as 00).
- `bpc`  in  32  branch target computed in ID.
- `jpc`  in  32  jump target computed in ID.
- `imem_addr`  out  32  instruction-memory address, equal to `pc`.
- `imem_rdata`  in  32  instruction word, combinational from `imem_addr`.
- `imem_ready`  in  1  high when `imem_rdata` is valid this cycle.
- `ex_wreg`  in  1  instruction in EX writes the register file.
- `ex_m2reg`  in  1  instruction in EX is a load.
- `ex_rn`  in  5  destination register of the instruction in EX.
- `pc`  out  32  current fetch PC.
- `id_inst`  out  32  IF/ID instruction register.
- `id_pc4`  out  32  IF/ID copy of fetch PC+4.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_bubble`  out  1  combinational; ID/EX must load a bubble with wreg=0 and wmem=0.
- `stall_cnt`  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- ID fields are decoded from `id_inst`:
  - op = [31:26]
  - rs = [25:21]
  - rt = [20:16]
- uses_rs: every opcode except j (010010).
- uses_rt: op 000000, 000001, 000010 (register ops), beq 001111, bne 010000, sw 001110.
- `stall` = `id_valid` & `ex_wreg` & `ex_m2reg` & (`ex_rn`≠0) & ((uses_rs & rs==`ex_rn`) | (uses_rt & rt==`ex_rn`)).
- `id_bubble` = `stall`.
- `redirect` = `id_valid` & !`stall` & (`pcsource`==01 | `pcsource`==10).
- Priority at each rising edge (first match wins):
  1. `resetn`=0: `pc`←`RESET_PC`; `id_inst`, `id_pc4`, `stall_cnt` ← 0; `id_valid`←0.
  2. `stall`: `pc` and IF/ID hold; `stall_cnt`+1, saturating at all-ones.
  3. `redirect`: `pc`←`bpc` (01) or `jpc` (10). IF/ID ← NOP (`id_inst`=0, `id_valid`=0, `id_pc4`=0). The word fetched this cycle is squashed, so there is no delay slot.
  4. `imem_ready`=0: `pc` holds; IF/ID ← NOP.
  5. Otherwise: `pc`←`pc`+4 (mod 2^32); `id_inst`←`imem_rdata`; `id_pc4`←`pc`+4; `id_valid`←1.
- `pcsource` is ignored when `id_valid`=0 or `stall`=1. The branch outcome in a stalled cycle is not yet final.
- `pcsource`=11 never redirects.

## Timing
- Reset values of outputs:
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`
  - `id_inst`=0, `id_pc4`=0, `id_valid`=0, `stall_cnt`=0
  - `id_bubble`=0, because `id_valid`=0.
- Fetch-to-ID latency: 1 cycle. A word returned with `imem_ready`=1 at edge N appears on `id_inst` after edge N.
- Branch/jump penalty: 1 cycle (one squashed slot).
- Load-use stall: exactly 1 cycle per hazard. The bubble moves the load to MEM, so `stall` clears next cycle without any extra state.
- Stall and redirect in the same cycle: stall wins and the redirect is re-evaluated next cycle.
- Redirect while `imem_ready`=0: the redirect still takes effect.
- `resetn` low mid-stall or mid-redirect: reset wins, and the first fetch after release is from `RESET_PC`.
- PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- `stall_cnt` holds at 2^CNT_W−1.

## Structure
- Shared CPU package holds:
  - opcode constants (R-type groups, addi/andi/ori/xori, lw 001101, sw 001110, beq, bne, j)
  - `pcsource` encodings
  - the NOP word
  - `RESET_PC` default
- One sub-module, `load_use_detect`, is combinational. It takes `id_inst`, `id_valid`, `ex_wreg`, `ex_m2reg`, `ex_rn` and produces `stall`.
- This block holds the PC register, IF/ID register, next-PC mux and counter.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles, then release with `imem_ready`=1 → `pc` = 0, 4, 8, …; `id_valid` rises one cycle after release; `id_pc4` = 4 with the first word.
- Load-use: lw r3 in EX (`ex_wreg`=1, `ex_m2reg`=1, `ex_rn`=3) with add rs=3 in ID → `id_bubble`=1 for one cycle; `pc` and `id_inst` hold; `stall_cnt` 0→1.
- rn=0 and j exemption:
  - `ex_rn`=0 with rs=0 → no stall.
  - j in ID whose [25:21]=`ex_rn` → no stall.
  - sw whose rt=`ex_rn` → stall.
- Branch taken: beq in ID with `pcsource`=01, `bpc`=32'h40 → next `pc`=32'h40; following cycle `id_valid`=0 and `id_inst`=0.
- Stall and jump together: `pcsource`=10 while a load-use hazard is present → `pc` holds; the jump to `jpc` happens on the next edge.
- `imem_ready`=0 for 3 cycles → `pc` holds; `id_valid`=0 for those cycles; normal flow resumes after.
- `stall_cnt` with `CNT_W`=2 and 5 stalls → value 3.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared CPU opcodes, pcsource encodings and fetch defaults.
package if_id_stage_pkg;

    localparam logic [5:0] OP_RTYPE0 = 6'b000000;
    localparam logic [5:0] OP_RTYPE1 = 6'b000001;
    localparam logic [5:0] OP_RTYPE2 = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b000011;
    localparam logic [5:0] OP_ANDI   = 6'b000100;
    localparam logic [5:0] OP_ORI    = 6'b000101;
    localparam logic [5:0] OP_XORI   = 6'b000110;
    localparam logic [5:0] OP_LW     = 6'b001101;
    localparam logic [5:0] OP_SW     = 6'b001110;
    localparam logic [5:0] OP_BEQ    = 6'b001111;
    localparam logic [5:0] OP_BNE    = 6'b010000;
    localparam logic [5:0] OP_J      = 6'b010010;

    typedef enum logic [1:0] {
        PCS_SEQ     = 2'b00,
        PCS_BRANCH  = 2'b01,
        PCS_JUMP    = 2'b10,
        PCS_ILLEGAL = 2'b11
    } pcsource_e;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    function automatic logic uses_rt(input logic [5:0] op);
        return op inside {OP_RTYPE0, OP_RTYPE1, OP_RTYPE2, OP_BEQ, OP_BNE, OP_SW};
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is still producing.
module load_use_detect
    import if_id_stage_pkg::*;
(
    input  logic [31:0] id_inst_i,
    input  logic        id_valid_i,
    input  logic        ex_wreg_i,
    input  logic        ex_m2reg_i,
    input  logic [4:0]  ex_rn_i,
    output logic        stall_o
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_imm;

    assign op         = id_inst_i[31:26];
    assign rs         = id_inst_i[25:21];
    assign rt         = id_inst_i[20:16];
    assign unused_imm = ^id_inst_i[15:0];

    // r0 is hardwired, so a load targeting it never creates a dependency
    assign stall_o = id_valid_i & ex_wreg_i & ex_m2reg_i & (ex_rn_i != 5'd0) &
                     (((op != OP_J) & (rs == ex_rn_i)) | (uses_rt(op) & (rt == ex_rn_i)));

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, next-PC mux, IF/ID pipeline register and load-use stall counter.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       pcsource,
    input  logic [31:0]      bpc,
    input  logic [31:0]      jpc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rn,
    output logic [31:0]      pc,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic             id_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [31:0]      pc_q, pc_d, inst_q, inst_d, pc4_q, pc4_d, pc_plus4;
    logic             valid_q, valid_d, stall, redirect, fetch;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    load_use_detect u_lud (
        .id_inst_i  (inst_q),
        .id_valid_i (valid_q),
        .ex_wreg_i  (ex_wreg),
        .ex_m2reg_i (ex_m2reg),
        .ex_rn_i    (ex_rn),
        .stall_o    (stall)
    );

    // stall outranks redirect because the branch outcome is not final until the hazard clears
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        redirect = valid_q & ~stall & ((pcsource == PCS_BRANCH) | (pcsource == PCS_JUMP));
        fetch    = ~stall & ~redirect & imem_ready;
        pc_d     = stall ? pc_q : redirect ? ((pcsource == PCS_BRANCH) ? bpc : jpc) : fetch ? pc_plus4 : pc_q;
        inst_d   = stall ? inst_q : fetch ? imem_rdata : NOP_WORD;
        pc4_d    = stall ? pc4_q : fetch ? pc_plus4 : 32'd0;
        valid_d  = stall ? valid_q : fetch;
        cnt_d    = (stall & ~&cnt_q) ? cnt_q + CNT_ONE : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign id_inst   = inst_q;
    assign id_pc4    = pc4_q;
    assign id_valid  = valid_q;
    assign id_bubble = stall;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed vectors with a scoreboard queue drained by an independent monitor.
module tb_if_id_stage;

    localparam logic [31:0] ADD3  = 32'h0064_0000; // op 000000 rs=3 rt=4
    localparam logic [31:0] J3    = 32'h4860_0000; // j with [25:21]=3
    localparam logic [31:0] SW13  = 32'h3823_0000; // sw rs=1 rt=3
    localparam logic [31:0] ADD00 = 32'h0000_0020; // op 000000 rs=0 rt=0
    localparam logic [31:0] ADDI  = 32'h0C43_0000; // addi rs=2 rt=3
    localparam logic [31:0] BEQ   = 32'h3CA6_0000; // beq rs=5 rt=6
    localparam logic [31:0] JW    = 32'h4800_0000;

    logic        clock = 1'b0;
    logic        resetn, imem_ready, ex_wreg, ex_m2reg, id_valid, id_bubble;
    logic [1:0]  pcsource, stall_cnt;
    logic [31:0] bpc, jpc, imem_addr, imem_rdata, pc, id_inst, id_pc4;
    logic [4:0]  ex_rn;

    typedef struct {
        int          id;
        logic [31:0] pc, inst, pc4;
        logic        valid, bub;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic bub_pre;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    if_id_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .ex_wreg    (ex_wreg),
        .ex_m2reg   (ex_m2reg),
        .ex_rn      (ex_rn),
        .pc         (pc),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid),
        .id_bubble  (id_bubble),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    // bubble is sampled before the edge it governs; state is sampled just after that edge
    always @(negedge clock) begin
        #2 bub_pre = id_bubble;
        @(posedge clock);
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk(mon_e.id, "id_bubble", {31'd0, bub_pre}, {31'd0, mon_e.bub});
            chk(mon_e.id, "pc", pc, mon_e.pc);
            chk(mon_e.id, "imem_addr", imem_addr, mon_e.pc);
            chk(mon_e.id, "id_inst", id_inst, mon_e.inst);
            chk(mon_e.id, "id_pc4", id_pc4, mon_e.pc4);
            chk(mon_e.id, "id_valid", {31'd0, id_valid}, {31'd0, mon_e.valid});
            chk(mon_e.id, "stall_cnt", {30'd0, stall_cnt}, {30'd0, mon_e.cnt});
        end
    end

    task automatic step(input int id, input logic rn_, input logic [1:0] ps, input logic [31:0] b,
                        input logic [31:0] j, input logic [31:0] rd, input logic rdy, input logic w,
                        input logic m, input logic [4:0] rn, input logic [31:0] epc,
                        input logic [31:0] einst, input logic [31:0] epc4, input logic ev,
                        input logic eb, input logic [1:0] ec);
        exp_t e;
        @(negedge clock);
        resetn = rn_; pcsource = ps; bpc = b; jpc = j; imem_rdata = rd; imem_ready = rdy;
        ex_wreg = w; ex_m2reg = m; ex_rn = rn;
        e.id = id; e.pc = epc; e.inst = einst; e.pc4 = epc4; e.valid = ev; e.bub = eb; e.cnt = ec;
        sbq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; pcsource = 2'b00; bpc = '0; jpc = '0; imem_rdata = '0; imem_ready = 1'b1;
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = '0;
        step(1,  0, 2'b00, 0, 0, ADD3, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(2,  0, 2'b00, 0, 0, ADD3, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(3,  1, 2'b00, 0, 0, ADD3, 1, 0, 0, 0, 32'h4, ADD3, 32'h4, 1, 0, 0);
        step(4,  1, 2'b00, 0, 0, 32'h1111_1111, 1, 1, 1, 3, 32'h4, ADD3, 32'h4, 1, 1, 1);
        step(5,  1, 2'b00, 0, 0, J3, 1, 0, 0, 0, 32'h8, J3, 32'h8, 1, 0, 1);
        step(6,  1, 2'b00, 0, 0, SW13, 1, 1, 1, 3, 32'hC, SW13, 32'hC, 1, 0, 1);
        step(7,  1, 2'b00, 0, 0, 32'h2222_2222, 1, 1, 1, 3, 32'hC, SW13, 32'hC, 1, 1, 2);
        step(8,  1, 2'b00, 0, 0, ADD00, 1, 0, 0, 0, 32'h10, ADD00, 32'h10, 1, 0, 2);
        step(9,  1, 2'b00, 0, 0, ADDI, 1, 1, 1, 0, 32'h14, ADDI, 32'h14, 1, 0, 2);
        step(10, 1, 2'b00, 0, 0, BEQ, 1, 1, 1, 3, 32'h18, BEQ, 32'h18, 1, 0, 2);
        step(11, 1, 2'b01, 32'h40, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 2);
        step(12, 1, 2'b01, 32'h80, 0, BEQ, 1, 0, 0, 0, 32'h44, BEQ, 32'h44, 1, 0, 2);
        step(13, 1, 2'b10, 0, 32'h100, 32'h3333_3333, 1, 1, 1, 6, 32'h44, BEQ, 32'h44, 1, 1, 3);
        step(14, 1, 2'b10, 0, 32'h100, 32'h3333_3333, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 0, 0, 3);
        for (int i = 15; i <= 17; i++)
            step(i, 1, 2'b00, 0, 0, ADD3, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 0, 0, 3);
        step(18, 1, 2'b00, 0, 0, ADD3, 1, 0, 0, 0, 32'h104, ADD3, 32'h104, 1, 0, 3);
        step(19, 1, 2'b00, 0, 0, ADD3, 1, 1, 1, 4, 32'h104, ADD3, 32'h104, 1, 1, 3);
        step(20, 1, 2'b00, 0, 0, ADD3, 1, 1, 1, 4, 32'h104, ADD3, 32'h104, 1, 1, 3);
        step(21, 1, 2'b11, 32'h500, 32'h500, JW, 1, 0, 0, 0, 32'h108, JW, 32'h108, 1, 0, 3);
        step(22, 1, 2'b10, 0, 32'hFFFF_FFFC, 32'h4444_4444, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 3);
        step(23, 1, 2'b00, 0, 0, 32'h1234_5678, 1, 0, 0, 0, 32'h0, 32'h1234_5678, 32'h0, 1, 0, 3);
        step(24, 0, 2'b00, 0, 0, ADD3, 1, 1, 1, 17, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        step(25, 1, 2'b00, 0, 0, ADD3, 1, 0, 0, 0, 32'h4, ADD3, 32'h4, 1, 0, 0);
        @(negedge clock);
        @(posedge clock);
        #3;
        chk(0, "scoreboard_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
